// File: rtl/texture_loader_pkg.sv
// Shared texture geometry constants, FSM encoding and the pixel-slice helper
// used by the texture loader.
package texture_loader_pkg;

  localparam int ADDR_BITS    = 12;
  localparam int BPP          = 3;
  localparam int PIX_PER_WORD = 8;
  localparam int PIX_BITS     = $clog2(PIX_PER_WORD);
  localparam int ROW_BITS     = ADDR_BITS - PIX_BITS;
  localparam int WORD_BITS    = BPP * PIX_PER_WORD;

  typedef enum logic {
    S_IDLE,
    S_UNPACK
  } state_e;

  function automatic logic [BPP-1:0] pix_of(input logic [WORD_BITS-1:0] w,
                                            input logic [PIX_BITS-1:0]  idx);
    return w[idx*BPP +: BPP];
  endfunction

endpackage

// File: rtl/texture_loader.sv
// iomem slave that takes one packed texture row per bus write and streams it
// out as one pixel per clock on the texture memory write port.
module texture_loader
  import texture_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 iomem_valid,
  output logic                 iomem_ready,
  input  logic [3:0]           iomem_wstrb,
  input  logic [31:0]          iomem_addr,
  input  logic [31:0]          iomem_wdata,
  output logic [31:0]          iomem_rdata,
  output logic                 tex_wen,
  output logic [ADDR_BITS-1:0] tex_waddr,
  output logic [BPP-1:0]       tex_wdata,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [PIX_BITS-1:0]  cnt_q, cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic                 ready_q, ready_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 wen_q, wen_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [BPP-1:0]       wdata_q, wdata_d;
  logic                 busy_q, busy_d;

  logic                req, is_wr, last, accept;
  logic [PIX_BITS-1:0] cnt_nxt;

  // Upper address bits belong to the SoC decoder; top wdata bits carry no pixels.
  logic unused_bits;
  assign unused_bits = &{1'b0, iomem_addr[31:ROW_BITS+2], iomem_addr[1:0],
                         iomem_wdata[31:WORD_BITS]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    row_d   = row_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // The ready guard stops the still-valid request from being taken twice.
    req     = sel & iomem_valid & ~ready_q;
    is_wr   = |iomem_wstrb;
    last    = (state_q == S_UNPACK) && (cnt_q == PIX_BITS'(PIX_PER_WORD - 1));
    accept  = req & is_wr & ((state_q == S_IDLE) | last);
    cnt_nxt = cnt_q + 1'b1;

    if (accept) begin
      word_d  = iomem_wdata[WORD_BITS-1:0];
      row_d   = iomem_addr[ROW_BITS+1:2];
      cnt_d   = '0;
      state_d = S_UNPACK;
      ready_d = 1'b1;
      rdata_d = '0;
      wen_d   = 1'b1;
      waddr_d = {iomem_addr[ROW_BITS+1:2], {PIX_BITS{1'b0}}};
      wdata_d = pix_of(iomem_wdata[WORD_BITS-1:0], '0);
    end else if (state_q == S_UNPACK) begin
      if (last) begin
        state_d = S_IDLE;
      end else begin
        cnt_d   = cnt_nxt;
        wen_d   = 1'b1;
        waddr_d = {row_q, cnt_nxt};
        wdata_d = pix_of(word_q, cnt_nxt);
      end
    end

    if (req && !is_wr) begin
      ready_d = 1'b1;
      rdata_d = {31'b0, busy_q};
    end

    busy_d = (state_d == S_UNPACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign tex_wen     = wen_q;
  assign tex_waddr   = waddr_q;
  assign tex_wdata   = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_texture_loader.sv
// Directed bench for texture_loader: a pixel-queue model checked every cycle,
// plus literal expectations per scenario.
module tb_texture_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        tex_wen;
  logic [11:0] tex_waddr;
  logic [2:0]  tex_wdata;
  logic        busy;

  always #5 clk = ~clk;

  texture_loader dut (
    .clk(clk), .reset(reset), .sel(sel), .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .tex_wen(tex_wen),
    .tex_waddr(tex_waddr), .tex_wdata(tex_wdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Model: pixels still to be written after the one on the port right now.
  // A new row is only taken once nothing is queued behind the current pixel.
  typedef struct { logic [11:0] a; logic [2:0] d; } pix_t;
  pix_t        mq[$];
  pix_t        mp;
  logic        m_ready, m_wen;
  logic [31:0] m_rdata;
  logic [11:0] m_waddr;
  logic [2:0]  m_wdata;
  bit          m_req, m_acc;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      m_ready = 0; m_rdata = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
      chk_en = 1;
    end else begin
      m_req = sel && iomem_valid && !m_ready;
      m_acc = 0;
      if (m_req && iomem_wstrb != 0 && mq.size() == 0) begin
        m_acc = 1;
        for (int i = 0; i < 8; i++) begin
          mp.a = {iomem_addr[10:2], 3'(i)};
          mp.d = iomem_wdata[3*i +: 3];
          mq.push_back(mp);
        end
        m_rdata = 0;
      end else if (m_req && iomem_wstrb == 0) begin
        m_rdata = {31'b0, m_wen};
      end
      m_ready = m_req && (m_acc || iomem_wstrb == 0);
      if (mq.size() > 0) begin
        mp = mq.pop_front();
        m_wen = 1; m_waddr = mp.a; m_wdata = mp.d;
      end else begin
        m_wen = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
      chk("wen",   {31'b0, tex_wen},     {31'b0, m_wen});
      chk("busy",  {31'b0, busy},        {31'b0, m_wen});
      chk("rdata", iomem_rdata,          m_rdata);
      chk("waddr", {20'b0, tex_waddr},   {20'b0, m_waddr});
      chk("wdata", {29'b0, tex_wdata},   {29'b0, m_wdata});
    end
  end

  typedef struct { int c; logic [11:0] a; logic [2:0] d; } log_t;
  log_t lg[$];
  log_t le;
  always @(negedge clk) begin
    if (tex_wen) begin
      le.c = cyc; le.a = tex_waddr; le.d = tex_wdata;
      lg.push_back(le);
    end
  end

  // Rows alternate ascending 0..7 then descending 7..0.
  function automatic int exp_pix(input int i);
    return ((i % 16) < 8) ? (i % 8) : (7 - (i % 8));
  endfunction

  task automatic check_log(input string nm, input int n, input int base);
    chk({nm, "_count"}, lg.size(), n);
    if (lg.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({nm, "_addr"}, {20'b0, lg[i].a}, base + i);
        chk({nm, "_data"}, {29'b0, lg[i].d}, exp_pix(i));
        chk({nm, "_gap"},  lg[i].c, lg[0].c + i);
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sel = 1; iomem_valid = 1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (iomem_ready) begin
        lat = k;
        break;
      end
    end
    sel = 0; iomem_valid = 0; iomem_wstrb = 0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=none expected=ready cyc=%0d", cyc);
    end
  endtask

  localparam logic [31:0] ROW_UP = 32'h00FA_C688;
  localparam logic [31:0] ROW_DN = 32'h0005_3977;

  int lat, bc, rc;

  initial begin
    ticks(3);
    chk("rst_ready", {31'b0, iomem_ready}, 0);
    chk("rst_wen",   {31'b0, tex_wen}, 0);
    chk("rst_rdata", iomem_rdata, 0);
    reset = 0;
    ticks(2);

    // 1: single row to row 0
    lg.delete();
    issue(32'h0, ROW_UP, 4'hF);
    wait_ack(lat);
    chk("s1_lat", lat, 1);
    chk("s1_rdata_wack", iomem_rdata, 0);
    bc = busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("s1_busy_cycles", bc, 8);
    check_log("s1", 8, 0);

    // 2: back-to-back rows 5 and 6, second with junk in the ignored top byte
    lg.delete();
    issue(32'd20, ROW_UP, 4'hF);
    wait_ack(lat);
    issue(32'd24, 32'hAB00_0000 | ROW_DN, 4'hF);
    wait_ack(lat);
    chk("s2_lat2", lat, 8);
    chk("s2_waddr_at_ack", {20'b0, tex_waddr}, 48);
    ticks(20);
    check_log("s2", 16, 40);

    // 3: write arriving mid-row (cnt==2), partial strobe
    lg.delete();
    issue(32'd8, ROW_UP, 4'hF);
    wait_ack(lat);
    ticks(2);
    issue(32'd12, ROW_DN, 4'b0001);
    wait_ack(lat);
    chk("s3_stall_lat", lat, 6);
    ticks(20);
    check_log("s3", 16, 16);

    // 4: status reads while busy and while idle
    lg.delete();
    issue(32'd4, ROW_UP, 4'hF);
    wait_ack(lat);
    ticks(2);
    issue(32'h0, 32'h0, 4'h0);
    wait_ack(lat);
    chk("s4_rd_lat", lat, 1);
    chk("s4_rd_busy", iomem_rdata, 1);
    ticks(20);
    check_log("s4", 8, 8);
    issue(32'h0, 32'h0, 4'h0);
    wait_ack(lat);
    chk("s4_rd_idle", iomem_rdata, 0);

    // 5: reset at cnt==3 aborts the row
    lg.delete();
    issue(32'h0, ROW_UP, 4'hF);
    wait_ack(lat);
    ticks(3);
    reset = 1;
    @(negedge clk);
    chk("s5_wen", {31'b0, tex_wen}, 0);
    chk("s5_busy", {31'b0, busy}, 0);
    chk("s5_ready", {31'b0, iomem_ready}, 0);
    reset = 0;
    ticks(5);
    check_log("s5_abort", 4, 0);
    lg.delete();
    issue(32'h0, ROW_UP, 4'hF);
    wait_ack(lat);
    chk("s5_lat", lat, 1);
    ticks(20);
    check_log("s5_after", 8, 0);

    // 6: no decode hit, then the top row with upper address junk
    lg.delete();
    sel = 0; iomem_valid = 1; iomem_wstrb = 4'hF; iomem_wdata = ROW_UP;
    rc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (iomem_ready) rc++;
    end
    iomem_valid = 0; iomem_wstrb = 0;
    chk("s6_nosel_ready", rc, 0);
    chk("s6_nosel_wen", lg.size(), 0);
    issue(32'hFFFF_F7FC, ROW_UP, 4'hF);
    wait_ack(lat);
    ticks(20);
    check_log("s6", 8, 4088);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
